// File: rtl/pulse_gen_n_pkg.sv
// Shared types and limits for the multi-channel pulse generator.
// The optional event counters are enabled by the macro PULSE_GEN_N_CNT_EN.
package pulse_gen_n_pkg;

  // Per-channel output FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Parameter limits
  localparam int MAX_CH   = 32;
  localparam int MIN_SYNC = 2;
  localparam int MAX_SYNC = 4;
  localparam int MAX_LEN  = 255;

  // Width of the pulse/gap down-counter (holds up to MAX_LEN-1)
  localparam int LEN_W = 8;

  // Clamp the requested synchroniser depth into the supported range
  function automatic int sync_depth(input int req);
    if (req < MIN_SYNC) return MIN_SYNC;
    if (req > MAX_SYNC) return MAX_SYNC;
    return req;
  endfunction

endpackage

// File: rtl/pulse_gen_n_chan.sv
// One channel: edge-capture latch, synchroniser, pulse/gap FSM with a
// one-deep pending slot, sticky overrun flag and (with PULSE_GEN_N_CNT_EN)
// a saturating event counter.
module pulse_gen_chan
  import pulse_gen_n_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int GAP_LEN     = 1
`ifdef PULSE_GEN_N_CNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pls_i,
  input  logic en_i,
  input  logic ovr_clr_i,
  output logic pls_o,
  output logic busy_o,
  output logic ovr_o
`ifdef PULSE_GEN_N_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  localparam int SYNC_N = sync_depth(SYNC_STAGES);
  localparam logic [LEN_W-1:0] PULSE_M1 = LEN_W'(PULSE_LEN - 1);
  localparam logic [LEN_W-1:0] GAP_M1   = LEN_W'(GAP_LEN - 1);

  // The capture "latch" is the inequality of two flops: set_q lives in the
  // pls_i domain and is forced to differ from clr_q (so repeated edges merge
  // into one event), clr_q lives in the clock domain and is made equal to
  // set_q once the event has travelled through the synchroniser.
  logic              set_q;
  logic              clr_q;
  logic              lat;
  logic [SYNC_N-1:0] sync_q;
  logic              strobe;

  assign lat    = set_q ^ clr_q;
  assign strobe = sync_q[SYNC_N-1];

  // Capture: any rising edge on pls_i marks an event
  always_ff @(posedge pls_i or negedge rst_ni) begin
    if (!rst_ni) set_q <= 1'b0;
    else         set_q <= ~clr_q;
  end

  // Synchronise the latch; a set last stage clears the latch and the chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      clr_q  <= 1'b0;
    end else if (strobe) begin
      sync_q <= '0;
      clr_q  <= set_q;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], lat};
    end
  end

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             pls_q, pls_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             strb_en;
  logic             pend_en;
  logic             drop;

  // Disabled channels ignore strobes and forget any pending event
  assign strb_en = strobe & en_i;
  assign pend_en = pend_q & en_i;

  // Next-state for the pulse/gap sequencer, pending slot and overrun flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_en;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strb_en) begin
          state_d = PULSE;
          cnt_d   = PULSE_M1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_M1;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
        if (strb_en) begin
          if (pend_en) drop   = 1'b1;
          else         pend_d = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (pend_en || strb_en) begin
            // Pending is consumed; a simultaneous strobe takes its place
            state_d = PULSE;
            cnt_d   = PULSE_M1;
            pend_d  = pend_en & strb_en;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          if (strb_en) begin
            if (pend_en) drop   = 1'b1;
            else         pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
    pls_d  = (state_d == PULSE);
    busy_d = (state_d != IDLE) | pend_d;
    // A new drop beats a simultaneous clear
    ovr_d  = drop ? 1'b1 : (ovr_clr_i ? 1'b0 : ovr_q);
  end

  // FSM and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pls_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pls_q   <= pls_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pls_o  = pls_q;
  assign busy_o = busy_q;
  assign ovr_o  = ovr_q;

`ifdef PULSE_GEN_N_CNT_EN
  logic [CNT_W-1:0] ev_q;

  // Count every enabled strobe, dropped ones included; saturate at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      ev_q <= '0;
    else if (strb_en && (ev_q != '1)) ev_q <= ev_q + CNT_W'(1);
  end

  assign cnt_o = ev_q;
`endif

endmodule

// File: rtl/pulse_gen_n.sv
// Multi-channel asynchronous-event to synchronous-pulse generator.
// Define PULSE_GEN_N_CNT_EN to add the per-channel ev_cnt counters.
module pulse_gen_n
  import pulse_gen_n_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int GAP_LEN     = 1
`ifdef PULSE_GEN_N_CNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N_CH-1:0] pls_in,
  input  logic [N_CH-1:0] chan_en,
  input  logic            ovr_clr,
  output logic [N_CH-1:0] pls_out,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] overrun
`ifdef PULSE_GEN_N_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0] ev_cnt
`endif
);

  // One independent channel per input bit; ovr_clr is shared
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pulse_gen_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .PULSE_LEN  (PULSE_LEN),
      .GAP_LEN    (GAP_LEN)
`ifdef PULSE_GEN_N_CNT_EN
      ,
      .CNT_W      (CNT_W)
`endif
    ) u_chan (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .pls_i    (pls_in[g]),
      .en_i     (chan_en[g]),
      .ovr_clr_i(ovr_clr),
      .pls_o    (pls_out[g]),
      .busy_o   (busy[g]),
      .ovr_o    (overrun[g])
`ifdef PULSE_GEN_N_CNT_EN
      ,
      .cnt_o    (ev_cnt[g*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
